// File: rtl/bus_pkg.sv
// Shared types and defaults for the two-master memory bus arbiter.
package bus_pkg;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE = 2'd0;
  localparam arb_state_t OWN0 = 2'd1;
  localparam arb_state_t OWN1 = 2'd2;

  typedef logic master_id_t;
  localparam master_id_t M0 = 1'b0;
  localparam master_id_t M1 = 1'b1;

  localparam int DEFAULT_RD_LATENCY = 1;
  localparam int DEFAULT_MAX_BURST  = 4;
  localparam int BURST_CNT_W        = 5;

  function automatic arb_state_t own_state(input master_id_t id);
    return (id == M1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-latency shift register of (valid, master id) tags that follows each
// read beat until its data arrives on the bus.
module rd_tag_pipe
  import bus_pkg::*;
#(
  parameter int DEPTH = DEFAULT_RD_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  input  master_id_t push_id,
  output logic       pop_valid,
  output master_id_t pop_id
);

  logic [DEPTH-1:0] valid_q;
  master_id_t       id_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Ids carry no meaning without their valid bit, so they are not reset.
  always_ff @(posedge clk) begin
    id_q[0] <= push_id;
    for (int i = 1; i < DEPTH; i++) begin
      id_q[i] <= id_q[i-1];
    end
  end

  assign pop_valid = valid_q[DEPTH-1];
  assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a shared memory bus with burst limiting
// and tagged read-data return. FSM state is visible as the 'state' signal.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wr_data_i,
  input  logic        m0_wr_en_i,
  output logic        m0_gnt_o,
  output logic        m0_stall_o,
  output logic [31:0] m0_rd_data_o,
  output logic        m0_rd_valid_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wr_data_i,
  input  logic        m1_wr_en_i,
  output logic        m1_gnt_o,
  output logic        m1_stall_o,
  output logic [31:0] m1_rd_data_o,
  output logic        m1_rd_valid_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wr_data_o,
  output logic        bus_wr_en_o,
  output logic        bus_rd_en_o,
  input  logic [31:0] bus_rd_data_i
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_BURST);

  arb_state_t             state, state_nxt;
  logic [BURST_CNT_W-1:0] burst_cnt, burst_cnt_nxt, burst_inc;
  master_id_t             last_owner, last_owner_nxt;
  master_id_t             owner;
  logic                   own_req, other_req, beat, owner_wr_en;
  logic                   tag_valid;
  master_id_t             tag_id;

  // Handshake: a master raises req with addr/data/wr_en and holds them until
  // the cycle where gnt=1; that cycle is the beat, and req may drop after it.
  // Reset gates every output so nothing leaks while state is being cleared.
  always_comb begin
    owner       = (state == OWN1) ? M1 : M0;
    own_req     = (owner == M1) ? m1_req_i : m0_req_i;
    other_req   = (owner == M1) ? m0_req_i : m1_req_i;
    owner_wr_en = (owner == M1) ? m1_wr_en_i : m0_wr_en_i;
    beat        = (state != IDLE) && own_req && !reset_i;
  end

  assign m0_gnt_o   = beat && (owner == M0);
  assign m1_gnt_o   = beat && (owner == M1);
  assign m0_stall_o = m0_req_i && !m0_gnt_o && !reset_i;
  assign m1_stall_o = m1_req_i && !m1_gnt_o && !reset_i;

  always_comb begin
    bus_addr_o    = '0;
    bus_wr_data_o = '0;
    bus_wr_en_o   = 1'b0;
    bus_rd_en_o   = 1'b0;
    if (beat) begin
      bus_addr_o    = (owner == M1) ? m1_addr_i : m0_addr_i;
      bus_wr_data_o = (owner == M1) ? m1_wr_data_i : m0_wr_data_i;
      bus_wr_en_o   = owner_wr_en;
      bus_rd_en_o   = !owner_wr_en;
    end
  end

  always_comb begin
    state_nxt      = state;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    burst_inc      = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (m0_req_i && m1_req_i) begin
          state_nxt = own_state(~last_owner);
        end else if (m0_req_i) begin
          state_nxt = OWN0;
        end else if (m1_req_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (own_req) begin
          last_owner_nxt = owner;
          // Hand over without a bubble once the burst budget is spent.
          if (other_req && (burst_inc >= BURST_MAX)) begin
            state_nxt     = own_state(~owner);
            burst_cnt_nxt = '0;
          end else begin
            burst_cnt_nxt = burst_inc;
          end
        end else begin
          burst_cnt_nxt = '0;
          state_nxt     = other_req ? own_state(~owner) : IDLE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_owner <= M1;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  rd_tag_pipe #(
    .DEPTH(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk       (clk_i),
    .reset     (reset_i),
    .push_valid(beat && !owner_wr_en),
    .push_id   (owner),
    .pop_valid (tag_valid),
    .pop_id    (tag_id)
  );

  assign m0_rd_data_o  = bus_rd_data_i;
  assign m1_rd_data_o  = bus_rd_data_i;
  assign m0_rd_valid_o = tag_valid && (tag_id == M0) && !reset_i;
  assign m1_rd_valid_o = tag_valid && (tag_id == M1) && !reset_i;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: default instance plus a
// MAX_BURST=1 instance for the alternating-grant scenario.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wr_en, m0_gnt, m0_stall, m0_rd_valid;
  logic [31:0] m0_addr, m0_wr_data, m0_rd_data;
  logic        m1_req, m1_wr_en, m1_gnt, m1_stall, m1_rd_valid;
  logic [31:0] m1_addr, m1_wr_data, m1_rd_data;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic        bus_wr_en, bus_rd_en;

  logic        b_m0_req, b_m1_req;
  logic        b_m0_gnt, b_m0_stall, b_m0_rd_valid, b_m1_gnt, b_m1_stall, b_m1_rd_valid;
  logic [31:0] b_m0_rd_data, b_m1_rd_data, b_bus_addr, b_bus_wr_data;
  logic        b_bus_wr_en, b_bus_rd_en;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  mem_bus_arbiter #(.RD_LATENCY(1), .MAX_BURST(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_wr_data_i(m0_wr_data), .m0_wr_en_i(m0_wr_en),
    .m0_gnt_o(m0_gnt), .m0_stall_o(m0_stall), .m0_rd_data_o(m0_rd_data), .m0_rd_valid_o(m0_rd_valid),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_wr_data_i(m1_wr_data), .m1_wr_en_i(m1_wr_en),
    .m1_gnt_o(m1_gnt), .m1_stall_o(m1_stall), .m1_rd_data_o(m1_rd_data), .m1_rd_valid_o(m1_rd_valid),
    .bus_addr_o(bus_addr), .bus_wr_data_o(bus_wr_data), .bus_wr_en_o(bus_wr_en),
    .bus_rd_en_o(bus_rd_en), .bus_rd_data_i(bus_rd_data)
  );

  mem_bus_arbiter #(.RD_LATENCY(1), .MAX_BURST(1)) dut_b (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(b_m0_req), .m0_addr_i(32'h10), .m0_wr_data_i(32'h0), .m0_wr_en_i(1'b1),
    .m0_gnt_o(b_m0_gnt), .m0_stall_o(b_m0_stall), .m0_rd_data_o(b_m0_rd_data), .m0_rd_valid_o(b_m0_rd_valid),
    .m1_req_i(b_m1_req), .m1_addr_i(32'h20), .m1_wr_data_i(32'h0), .m1_wr_en_i(1'b1),
    .m1_gnt_o(b_m1_gnt), .m1_stall_o(b_m1_stall), .m1_rd_data_o(b_m1_rd_data), .m1_rd_valid_o(b_m1_rd_valid),
    .bus_addr_o(b_bus_addr), .bus_wr_data_o(b_bus_wr_data), .bus_wr_en_o(b_bus_wr_en),
    .bus_rd_en_o(b_bus_rd_en), .bus_rd_data_i(32'h0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model (one-cycle read latency) ----------------
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) bus_rd_data <= bus_rd_en ? mem_val(bus_addr) : 32'h0;

  // ---------------- scoreboard: read returns ----------------
  always @(negedge clk) begin
    if (m0_rd_valid || m1_rd_valid) begin
      logic [32:0] exp_v, got_v;
      n_checks++;
      got_v = {m1_rd_valid, (m1_rd_valid ? m1_rd_data : m0_rd_data)};
      if (m0_rd_valid && m1_rd_valid) begin
        n_fail++;
        $display("FAIL rd_valid_both: got m0=1 m1=1 expected one-hot");
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got id=%0d data=%h expected no return", got_v[32], got_v[31:0]);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL rd_return: got id=%0d data=%h expected id=%0d data=%h",
                   got_v[32], got_v[31:0], exp_v[32], exp_v[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks / scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    m0_req = 1'b1; m0_addr = 32'hAAAA_0000; m0_wr_data = 32'h1111_1111; m0_wr_en = 1'b0;
    m1_req = 1'b1; m1_addr = 32'hBBBB_0000; m1_wr_data = 32'h2222_2222; m1_wr_en = 1'b0;
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_stall, m1_stall} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt_stall: got %b expected 0000", {m0_gnt, m1_gnt, m0_stall, m1_stall});
    end
    n_checks++;
    if ({bus_wr_en, bus_rd_en, m0_rd_valid, m1_rd_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus_wr_en, bus_rd_en, m0_rd_valid, m1_rd_valid});
    end
    n_checks++;
    if ({bus_addr, bus_wr_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h data=%h expected 0", bus_addr, bus_wr_data);
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_v;
    tick();
    reset = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h1000; m0_wr_data = 32'hC0DE_0000; m0_wr_en = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h2000; m1_wr_data = 32'hC0DE_0001; m1_wr_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      exp_v = (c == 0) ? 4'b0011 : (c <= 4) ? 4'b1001 : 4'b0110;
      n_checks++;
      if ({m0_gnt, m1_gnt, m0_stall, m1_stall} !== exp_v) begin
        n_fail++;
        $display("FAIL burst_gnt c%0d: got %b expected %b", c, {m0_gnt, m1_gnt, m0_stall, m1_stall}, exp_v);
      end
      if (c == 2 || c == 5) begin
        n_checks++;
        if ({bus_wr_en, bus_rd_en, bus_addr} !== {2'b10, (c == 2) ? 32'h1000 : 32'h2000}) begin
          n_fail++;
          $display("FAIL burst_bus c%0d: got we=%b re=%b addr=%h", c, bus_wr_en, bus_rd_en, bus_addr);
        end
      end
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_write_m0();
    m0_req = 1'b1; m0_addr = 32'h40; m0_wr_data = 32'h1234_5678; m0_wr_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m0_stall, bus_wr_en, bus_rd_en} !== 4'b0100) begin
      n_fail++;
      $display("FAIL wr_arb_cycle: got %b expected 0100", {m0_gnt, m0_stall, bus_wr_en, bus_rd_en});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m0_stall, bus_wr_en, bus_rd_en} !== 4'b1010) begin
      n_fail++;
      $display("FAIL wr_beat_strobes: got %b expected 1010", {m0_gnt, m0_stall, bus_wr_en, bus_rd_en});
    end
    n_checks++;
    if ({bus_addr, bus_wr_data} !== {32'h40, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL wr_beat_bus: got addr=%h data=%h expected 00000040 12345678", bus_addr, bus_wr_data);
    end
    tick();
    m0_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m0_stall, bus_wr_en, bus_addr} !== 35'h0) begin
      n_fail++;
      $display("FAIL wr_after: got gnt=%b stall=%b we=%b addr=%h expected 0", m0_gnt, m0_stall, bus_wr_en, bus_addr);
    end
    tick();
  endtask

  task automatic test_read_m1();
    m1_req = 1'b1; m1_addr = 32'h100; m1_wr_en = 1'b0;
    exp_q.push_back({1'b1, 32'hDEADBEEF});
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, bus_rd_en, bus_wr_en, bus_addr} !== {3'b110, 32'h100}) begin
      n_fail++;
      $display("FAIL rd_m1_beat: got gnt=%b re=%b we=%b addr=%h", m1_gnt, bus_rd_en, bus_wr_en, bus_addr);
    end
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m0_rd_valid, m1_rd_valid, m1_rd_data} !== {2'b01, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL rd_m1_return: got v0=%b v1=%b data=%h expected 0 1 deadbeef", m0_rd_valid, m1_rd_valid, m1_rd_data);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_rd_valid, m1_rd_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_m1_single_pulse: got %b expected 00", {m0_rd_valid, m1_rd_valid});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v;
    m0_req = 1'b1; m0_addr = 32'h0; m0_wr_en = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h4; m1_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, mem_val(32'h0)});
    exp_q.push_back({1'b1, mem_val(32'h4)});
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      case (c)
        0:       exp_v = 4'b0000;
        1:       exp_v = 4'b1000;
        2, 3, 4: exp_v = 4'b1010;
        5:       exp_v = 4'b0110;
        default: exp_v = 4'b0001;
      endcase
      n_checks++;
      if ({m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid} !== exp_v) begin
        n_fail++;
        $display("FAIL b2b c%0d: got gnt/valid %b expected %b", c, {m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid}, exp_v);
      end
      tick();
      if (c == 4) m0_req = 1'b0;
      if (c == 5) m1_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_read();
    m0_req = 1'b1; m0_addr = 32'h80; m0_wr_en = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, bus_rd_en} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_rd_beat: got gnt=%b re=%b expected 1 1", m0_gnt, bus_rd_en);
    end
    tick();
    reset = 1'b1;
    m0_req = 1'b1; m0_wr_en = 1'b1; m1_req = 1'b1; m1_wr_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt, m0_stall, m1_stall, bus_wr_en, bus_rd_en, m0_rd_valid, m1_rd_valid, bus_addr} !== 40'h0) begin
        n_fail++;
        $display("FAIL rst_outputs c%0d: got gnt=%b%b valid=%b%b we=%b re=%b addr=%h expected 0", c,
                 m0_gnt, m1_gnt, m0_rd_valid, m1_rd_valid, bus_wr_en, bus_rd_en, bus_addr);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_first_tie: got %b expected 10", {m0_gnt, m1_gnt});
    end
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0] exp_v;
    b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_v = (c == 0) ? 2'b00 : (c % 2 == 1) ? 2'b10 : 2'b01;
      n_checks++;
      if ({b_m0_gnt, b_m1_gnt} !== exp_v) begin
        n_fail++;
        $display("FAIL alt_gnt c%0d: got %b expected %b", c, {b_m0_gnt, b_m1_gnt}, exp_v);
      end
      tick();
    end
    b_m0_req = 1'b0; b_m1_req = 1'b0;
    tick();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus_rd_data = 32'h0;
    test_reset();
    test_burst();
    test_write_m0();
    test_read_m1();
    test_back_to_back();
    test_reset_mid_read();
    test_alternate();
    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_drain: got %0d outstanding returns expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  RD_LATENCY, 1, cycles from read beat to bus_rd_data_i valid (1..4)
  MAX_BURST, 4, max consecutive beats granted to one master while the other is requesting (1..16)
REQ-002 Ports SHALL be, one per line:
  clk_i  in  1  single clock; all state updates on its rising edge
  reset_i  in  1  synchronous, active-high reset
  m0_req_i  in  1  master 0 (CPU Memory stage) requests a beat
  m0_addr_i  in  32  master 0 byte address
  m0_wr_data_i  in  32  master 0 write data
  m0_wr_en_i  in  1  master 0 write (1) / read (0)
  m0_gnt_o  out  1  master 0 beat accepted this cycle
  m0_stall_o  out  1  m0_req_i & ~m0_gnt_o, to hazard unit
  m0_rd_data_o  out  32  master 0 read return data
  m0_rd_valid_o  out  1  master 0 read return strobe
  m1_req_i, m1_addr_i, m1_wr_data_i, m1_wr_en_i, m1_gnt_o, m1_rd_data_o, m1_rd_valid_o  same as master 0 (master 1 = GPU/DMA port)
  bus_addr_o  out  32  shared memory bus address
  bus_wr_data_o  out  32  shared bus write data
  bus_wr_en_o  out  1  shared bus write strobe
  bus_rd_en_o  out  1  shared bus read strobe
  bus_rd_data_i  in  32  read data, RD_LATENCY cycles after bus_rd_en_o

Function
REQ-003 FSM states SHALL be IDLE, OWN0, OWN1; a beat occurs for master x only when state is OWNx and mx_req_i=1, and mx_gnt_o SHALL be 1 exactly then (combinational from state and req).
REQ-004 IDLE: grant-less; if any req, next state SHALL be OWN of the winner; one-cycle arbitration latency.
REQ-005 Simultaneous requests in IDLE SHALL be resolved round-robin: winner is the master not recorded in last_owner.
REQ-006 OWNx: burst counter SHALL increment per beat; last_owner SHALL be set to x on each beat.
REQ-007 OWNx, other master requesting, and counter reaches MAX_BURST on this beat -> next state SHALL be OWN(other), counter cleared; no idle bubble.
REQ-008 OWNx with mx_req_i=0: next state SHALL be OWN(other) if other requests, else IDLE; counter cleared.
REQ-009 OWNx with other master not requesting SHALL keep granting x indefinitely (counter saturates at MAX_BURST).
REQ-010 During a beat, bus_addr_o/bus_wr_data_o SHALL equal the owner's inputs, bus_wr_en_o = owner wr_en, bus_rd_en_o = ~owner wr_en; with no beat, all four bus outputs SHALL be 0.
REQ-011 Each read beat SHALL push a tag (valid, master id) into a RD_LATENCY-deep pipe; on tag exit the tagged master's rd_valid_o SHALL pulse for one cycle with rd_data_o = bus_rd_data_i; the other master's rd_valid_o stays 0.
REQ-012 rd_data_o of both masters SHALL be driven from bus_rd_data_i continuously; only rd_valid_o qualifies it.
REQ-013 Back-to-back reads, including across an owner switch, SHALL return in issue order at one per cycle.
REQ-014 Requesters SHALL hold addr/data/wr_en stable while req=1 and gnt=0; the arbiter SHALL NOT latch inputs.

Reset
REQ-015 While reset_i=1 at a clock edge: state=IDLE, counter=0, last_owner=1 (master 0 wins first tie), read tag pipe cleared.
REQ-016 Outputs during and after reset SHALL be 0 (gnt, rd_valid, bus strobes, bus_addr_o, bus_wr_data_o) until the first post-reset grant; reads in flight at reset SHALL produce no rd_valid.

Structure
REQ-017 Shared package bus_pkg SHALL hold arb_state_t (IDLE/OWN0/OWN1), master_id_t, and RD_LATENCY/MAX_BURST defaults.
REQ-018 One sub-module rd_tag_pipe (parameterised shift register of valid+id) SHALL implement REQ-011; all else inline.

Verification
REQ-019 Both reqs at cycle 0 after reset -> OWN0 at cycle 1, m0_gnt_o=1 for 4 beats, OWN1 at cycle 5 with no bubble.
REQ-020 m1 read 0x100 alone, memory returns 0xDEADBEEF at RD_LATENCY=1 -> m1_rd_valid_o pulses once with 0xDEADBEEF, m0_rd_valid_o stays 0.
REQ-021 m0 write 0x40=0x12345678 while m1 idle -> bus_wr_en_o=1, bus_addr_o=0x40, bus_wr_data_o=0x12345678 for one cycle; m0_stall_o=1 only in IDLE arbitration cycle.
REQ-022 m0 reads 0x0, m1 reads 0x4 back-to-back across switch -> returns in order, one rd_valid per master on consecutive cycles.
REQ-023 reset_i asserted the cycle after a read beat -> no rd_valid ever, all outputs 0, next tie grants m0.
REQ-024 MAX_BURST=1, both reqs held -> grants alternate m0,m1,m0,m1 every cycle.
